// File: rtl/seq_timer_pkg.sv
// Shared constants and types for the seq_timer control front end and the
// minutes/seconds counter it feeds.
package seq_timer_pkg;

  localparam int DEFAULT_CYCLES_PER_TICK = 100;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // mins/secs field as consumed by the downstream count timer
  typedef logic [5:0] time_field_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_timer_ctrl_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button.
// press is high in the cycle before the edge on which level rises 0 -> 1.
module seq_timer_ctrl_debounce
  import seq_timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = btn;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulse is taken from the next-state so the top acts on the same edge
  // that commits the new level.
  assign press = level_d & ~level_q;
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_timer_ctrl.sv
// Button front end for the minutes/seconds timer: run toggle, restart pulse
// and run-gated tick prescaler. Define SEQ_TIMER_CTRL_RESTART_STOPS_EN to make
// a restart press also stop the timer.
module seq_timer_ctrl
  import seq_timer_pkg::*;
#(
  parameter int CYCLES_PER_TICK = DEFAULT_CYCLES_PER_TICK,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_stop_btn,
  input  logic restart_btn,
  output logic run,
  output logic tick,
  output logic restart
);

  localparam int CNT_W = cnt_width(CYCLES_PER_TICK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_TICK - 1);

  logic             ss_level, ss_press;
  logic             rs_level, rs_press;
  logic             unused_levels;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  seq_timer_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (start_stop_btn),
    .level   (ss_level),
    .press   (ss_press)
  );

  seq_timer_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rs_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (restart_btn),
    .level   (rs_level),
    .press   (rs_press)
  );

  // Only press events matter here; releases are deliberately ignored.
  assign unused_levels = ss_level ^ rs_level;

  always_comb begin
    run_d = run_q ^ ss_press;
`ifdef SEQ_TIMER_CTRL_RESTART_STOPS_EN
    if (rs_press) run_d = 1'b0;
`else
    run_d = run_d;
`endif
    restart_d = rs_press;
  end

  // Prescaler looks at the pre-edge run, so the pausing edge still counts.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (rs_press) begin
      cnt_d = '0;
    end else if (run_q && (cnt_q == CNT_LAST)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      run_q     <= run_d;
      tick_q    <= tick_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
    end
  end

  assign run     = run_q;
  assign tick    = tick_q;
  assign restart = restart_q;

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// Directed bench for seq_timer_ctrl with CYCLES_PER_TICK=4, DEBOUNCE_CYCLES=3.
// Expected run/tick/restart values are hand-derived edge by edge.
module tb_seq_timer_ctrl;

  localparam int CPT = 4;
  localparam int DB  = 3;
`ifdef SEQ_TIMER_CTRL_RESTART_STOPS_EN
  localparam bit STOPS = 1'b1;
`else
  localparam bit STOPS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_stop_btn = 1'b0;
  logic restart_btn = 1'b0;
  logic run, tick, restart;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  seq_timer_ctrl #(.CYCLES_PER_TICK(CPT), .DEBOUNCE_CYCLES(DB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_stop_btn (start_stop_btn),
    .restart_btn    (restart_btn),
    .run            (run),
    .tick           (tick),
    .restart        (restart)
  );

  // Advance past one rising edge and settle before sampling or driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int k);
    check({tag, "_run"}, k, run, 1'b0);
    check({tag, "_tick"}, k, tick, 1'b0);
    check({tag, "_restart"}, k, restart, 1'b0);
  endtask

  initial begin
    logic exp_tick;
    logic exp_run;

    // reset state, then idle buttons
    reset_n = 1'b0;
    repeat (3) cyc();
    check_idle("reset", 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check_idle("idle", k);
    end

    // 1- and 2-cycle glitches are shorter than the debounce window
    for (int w = 1; w <= 2; w++) begin
      start_stop_btn = 1'b1;
      repeat (w) cyc();
      start_stop_btn = 1'b0;
      for (int k = 0; k < 10; k++) begin
        cyc();
        check("glitch_run", k, run, 1'b0);
        check("glitch_tick", k, tick, 1'b0);
      end
    end

    // start, pause at count 2, resume: tick edges pushed as expected times
    exp_q = {8'd9, 8'd13, 8'd17, 8'd21, 8'd37, 8'd41};
    start_stop_btn = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      cyc();
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == 8'(k));
      if (exp_tick) void'(exp_q.pop_front());
      exp_run = ((k >= 5) && (k <= 22)) || (k >= 35);
      check("run_seq_run", k, run, exp_run);
      check("run_seq_tick", k, tick, exp_tick);
      check("run_seq_restart", k, restart, 1'b0);
      start_stop_btn = (k < 10) || ((k >= 18) && (k < 23)) || ((k >= 30) && (k < 35));
    end
    check("tick_queue_drained", 0, exp_q.size() == 0, 1'b1);

    // reset mid-count while running
    reset_n = 1'b0;
    cyc();
    check_idle("midreset", 0);
    cyc();
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check_idle("post_reset", k);
    end

    // both buttons pressed on the same cycle while stopped
    start_stop_btn = 1'b1;
    restart_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("both_run", k, run, (k >= 5) ? !STOPS : 1'b0);
      check("both_restart", k, restart, k == 5);
      check("both_tick", k, tick, 1'b0);
      start_stop_btn = (k < 6);
      restart_btn = (k < 6);
    end
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;

    // start, then restart while running
    start_stop_btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      exp_run = STOPS ? ((k >= 5) && (k <= 14)) : (k >= 5);
      exp_tick = (k == 9) || (k == 13) || (!STOPS && ((k == 19) || (k == 23)));
      check("rst_run", k, run, exp_run);
      check("rst_tick", k, tick, exp_tick);
      check("rst_restart", k, restart, k == 15);
      start_stop_btn = (k < 6);
      restart_btn = (k >= 10) && (k < 17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
